// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes, PC enable, EX forwarding selects, drain and halt.
// Optional macro FORWARDING_EN enables EX-stage forwarding; without it RAW hazards on ID/EX and EX/MEM stall.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_BITS     = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ihit,
    input  logic                dhit,
    input  logic                branch_taken,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic [REG_BITS-1:0] idex_rs1,
    input  logic [REG_BITS-1:0] idex_rs2,
    input  logic [REG_BITS-1:0] idex_rd,
    input  logic                idex_RegWr,
    input  logic                idex_dmemREN,
    input  logic [REG_BITS-1:0] exmem_rd,
    input  logic                exmem_RegWr,
    input  logic                exmem_dmemREN,
    input  logic                exmem_MemWr,
    input  logic                exmem_halt,
    input  logic [REG_BITS-1:0] memwr_rd,
    input  logic                memwr_RegWr,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                exmem_en,
    output logic                memwr_en,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic [1:0]          fwdA,
    output logic [1:0]          fwdB,
    output logic                halt,
    output logic [CNT_W-1:0]    stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        DRAIN,
        HALTED
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwr_en;
        logic ifid_flush;
        logic idex_flush;
    } ctl_t;

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES < 1) ? 0 : DRAIN_CYCLES - 1);

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic   dmem_miss;
    logic   raw_stall;
    ctl_t   run_ctl;
    state_t run_next;
    ctl_t   cur_ctl;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic writes(input logic we, input logic [REG_BITS-1:0] rd);
        return we && (rd != '0);
    endfunction

    function automatic logic reads_id(input logic [REG_BITS-1:0] rd,
                                      input logic [REG_BITS-1:0] rs1,
                                      input logic [REG_BITS-1:0] rs2);
        return (rd == rs1) || (rd == rs2);
    endfunction

    function automatic ctl_t mk_ctl(input logic pc, input logic ifid, input logic idex,
                                    input logic exmem, input logic memwr,
                                    input logic ifid_fl, input logic idex_fl);
        ctl_t c;
        c.pc_en      = pc;
        c.ifid_en    = ifid;
        c.idex_en    = idex;
        c.exmem_en   = exmem;
        c.memwr_en   = memwr;
        c.ifid_flush = ifid_fl;
        c.idex_flush = idex_fl;
        return c;
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] rs,
                                           input logic                em_wr,
                                           input logic [REG_BITS-1:0] em_rd,
                                           input logic                em_load,
                                           input logic                mw_wr,
                                           input logic [REG_BITS-1:0] mw_rd);
        if (writes(em_wr, em_rd) && !em_load && (em_rd == rs)) begin
            return 2'b01;
        end
        if (writes(mw_wr, mw_rd) && (mw_rd == rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction
`endif

    // Hazard detection on the ID-stage sources
    always_comb begin
        dmem_miss = (exmem_dmemREN | exmem_MemWr) & ~dhit;
`ifdef FORWARDING_EN
        raw_stall = idex_dmemREN && writes(idex_RegWr, idex_rd)
                    && reads_id(idex_rd, id_rs1, id_rs2);
`else
        // mem_wr producer is covered by the write-before-read regfile
        raw_stall = (writes(idex_RegWr, idex_rd) && reads_id(idex_rd, id_rs1, id_rs2))
                 || (writes(exmem_RegWr, exmem_rd) && reads_id(exmem_rd, id_rs1, id_rs2));
`endif
    end

`ifndef FORWARDING_EN
    logic unused_fwd_inputs;
    always_comb begin
        unused_fwd_inputs = ^{idex_rs1, idex_rs2, memwr_rd, memwr_RegWr, idex_dmemREN};
    end
`endif

    // RUN-state priority evaluation, also reused when DWAIT sees dhit
    always_comb begin
        run_next = RUN;
        if (exmem_halt) begin
            run_ctl  = mk_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            run_next = DRAIN;
        end else if (dmem_miss) begin
            run_ctl  = mk_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            run_next = DWAIT;
        end else if (branch_taken) begin
            run_ctl  = mk_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        end else if (raw_stall) begin
            run_ctl  = mk_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        end else if (!ihit) begin
            run_ctl  = mk_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        end else begin
            run_ctl  = mk_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= RUN;
            drain_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = '0;
        case (state_q)
            RUN: begin
                state_d = run_next;
            end
            DWAIT: begin
                if (dhit) begin
                    state_d = run_next;
                end
            end
            DRAIN: begin
                drain_cnt_d = dmem_miss ? drain_cnt_q : drain_cnt_q + DRAIN_W'(1);
                if (!dmem_miss && (drain_cnt_q == DRAIN_LAST)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        cur_ctl = mk_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (RST) begin
            cur_ctl = mk_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end else begin
            case (state_q)
                RUN:     cur_ctl = run_ctl;
                DWAIT:   if (dhit) cur_ctl = run_ctl;
                DRAIN:   cur_ctl = mk_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
                default: cur_ctl = mk_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
`ifdef FORWARDING_EN
            fwd_a = fwd_sel(idex_rs1, exmem_RegWr, exmem_rd, exmem_dmemREN, memwr_RegWr, memwr_rd);
            fwd_b = fwd_sel(idex_rs2, exmem_RegWr, exmem_rd, exmem_dmemREN, memwr_RegWr, memwr_rd);
`endif
        end
        pc_en      = cur_ctl.pc_en;
        ifid_en    = cur_ctl.ifid_en;
        idex_en    = cur_ctl.idex_en;
        exmem_en   = cur_ctl.exmem_en;
        memwr_en   = cur_ctl.memwr_en;
        ifid_flush = cur_ctl.ifid_flush;
        idex_flush = cur_ctl.idex_flush;
        fwdA       = fwd_a;
        fwdB       = fwd_b;
        halt       = (state_q == HALTED);
    end

    // Saturating count of PC-stalled cycles outside HALTED
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!cur_ctl.pc_en && (state_q != HALTED) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a
// table-driven behavioural model. Honours FORWARDING_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

    localparam int DC   = 3;
    localparam int CW   = 8;
    localparam int SMAX = (1 << CW) - 1;

    logic       CLK;
    logic       RST;
    logic       ihit, dhit, branch_taken;
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwr_rd;
    logic       idex_RegWr, idex_dmemREN;
    logic       exmem_RegWr, exmem_dmemREN, exmem_MemWr, exmem_halt;
    logic       memwr_RegWr;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_flush;
    logic [1:0] fwdA, fwdB;
    logic       halt;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_ctrl #(
        .REG_BITS    (5),
        .DRAIN_CYCLES(DC),
        .CNT_W       (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .branch_taken (branch_taken),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .idex_rs1     (idex_rs1),
        .idex_rs2     (idex_rs2),
        .idex_rd      (idex_rd),
        .idex_RegWr   (idex_RegWr),
        .idex_dmemREN (idex_dmemREN),
        .exmem_rd     (exmem_rd),
        .exmem_RegWr  (exmem_RegWr),
        .exmem_dmemREN(exmem_dmemREN),
        .exmem_MemWr  (exmem_MemWr),
        .exmem_halt   (exmem_halt),
        .memwr_rd     (memwr_rd),
        .memwr_RegWr  (memwr_RegWr),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwr_en     (memwr_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .halt         (halt),
        .stall_cycles (stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_RUN, M_DWAIT, M_DRAIN, M_HALTED} mode_e;

    typedef struct {
        bit [6:0] v;      // {pc, ifid_en, idex_en, exmem_en, memwr_en, ifid_fl, idex_fl}
        int       rule;
        bit       dmiss;
        int       fa;
        int       fb;
    } exp_t;

    mode_e m_mode    = M_RUN;
    int    m_drained = 0;
    int    m_stall   = 0;
    bit    m_valid   = 1'b0;

    function automatic bit wr(input bit we, input int rd);
        return we && (rd != 0);
    endfunction

    function automatic bit hits_id(input int rd);
        return (rd == int'(id_rs1)) || (rd == int'(id_rs2));
    endfunction

    function automatic bit raw_hazard();
`ifdef FORWARDING_EN
        return idex_dmemREN && wr(idex_RegWr, int'(idex_rd)) && hits_id(int'(idex_rd));
`else
        return (wr(idex_RegWr, int'(idex_rd)) && hits_id(int'(idex_rd)))
            || (wr(exmem_RegWr, int'(exmem_rd)) && hits_id(int'(exmem_rd)));
`endif
    endfunction

    function automatic int fwd_of(input int rs);
`ifdef FORWARDING_EN
        if (wr(exmem_RegWr, int'(exmem_rd)) && !exmem_dmemREN && int'(exmem_rd) == rs) return 1;
        if (wr(memwr_RegWr, int'(memwr_rd)) && int'(memwr_rd) == rs) return 2;
`endif
        return 0;
    endfunction

    function automatic bit [6:0] rule_vec(input int r);
        case (r)
            1:       return 7'b0111111;
            2:       return 7'b0000000;
            3:       return 7'b1111111;
            4:       return 7'b0011101;
            5:       return 7'b0111110;
            default: return 7'b1111100;
        endcase
    endfunction

    function automatic exp_t model_now(input mode_e mode);
        exp_t e;
        e.dmiss = (exmem_dmemREN || exmem_MemWr) && !dhit;
        if (exmem_halt)        e.rule = 1;
        else if (e.dmiss)      e.rule = 2;
        else if (branch_taken) e.rule = 3;
        else if (raw_hazard()) e.rule = 4;
        else if (!ihit)        e.rule = 5;
        else                   e.rule = 6;
        e.fa = 0;
        e.fb = 0;
        if (RST) begin
            e.v = 7'b0000011;
        end else begin
            case (mode)
                M_RUN:   e.v = rule_vec(e.rule);
                M_DWAIT: e.v = dhit ? rule_vec(e.rule) : 7'b0000000;
                M_DRAIN: e.v = 7'b0111111;
                default: e.v = 7'b0000000;
            endcase
            e.fa = fwd_of(int'(idex_rs1));
            e.fb = fwd_of(int'(idex_rs2));
        end
        return e;
    endfunction

    // Model state advance at each active edge
    initial begin
        exp_t ep;
        forever begin
            @(posedge CLK);
            ep = model_now(m_mode);
            if (RST) begin
                m_mode    = M_RUN;
                m_drained = 0;
                m_stall   = 0;
                m_valid   = 1'b1;
            end else if (m_valid) begin
                if (!ep.v[6] && m_mode != M_HALTED && m_stall < SMAX) m_stall++;
                case (m_mode)
                    M_RUN: begin
                        if (ep.rule == 1) begin
                            m_mode = M_DRAIN;
                            m_drained = 0;
                        end else if (ep.rule == 2) begin
                            m_mode = M_DWAIT;
                        end
                    end
                    M_DWAIT: begin
                        if (dhit) begin
                            m_mode = (ep.rule == 1) ? M_DRAIN : M_RUN;
                            m_drained = 0;
                        end
                    end
                    M_DRAIN: begin
                        if (!ep.dmiss) begin
                            m_drained++;
                            if (m_drained == DC) m_mode = M_HALTED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        exp_t en;
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                en = model_now(m_mode);
                chk("pc_en", int'(pc_en), int'(en.v[6]));
                if (RST || !en.v[1]) chk("ifid_en", int'(ifid_en), int'(en.v[5]));
                if (RST || !en.v[0]) chk("idex_en", int'(idex_en), int'(en.v[4]));
                chk("exmem_en", int'(exmem_en), int'(en.v[3]));
                chk("memwr_en", int'(memwr_en), int'(en.v[2]));
                chk("ifid_flush", int'(ifid_flush), int'(en.v[1]));
                chk("idex_flush", int'(idex_flush), int'(en.v[0]));
                chk("fwdA", int'(fwdA), en.fa);
                chk("fwdB", int'(fwdB), en.fb);
                chk("halt", int'(halt), (m_mode == M_HALTED) ? 1 : 0);
                chk("stall_cycles", int'(stall_cycles), m_stall);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; branch_taken = 1'b0;
        id_rs1 = '0; id_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
        idex_RegWr = 1'b0; idex_dmemREN = 1'b0;
        exmem_rd = '0; exmem_RegWr = 1'b0; exmem_dmemREN = 1'b0; exmem_MemWr = 1'b0; exmem_halt = 1'b0;
        memwr_rd = '0; memwr_RegWr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_ifid_flush", int'(ifid_flush), 1);
        chk("rst_idex_flush", int'(idex_flush), 1);
        cyc(); RST = 1'b0;
        @(negedge CLK);
        chk("t1_pc_en", int'(pc_en), 1);
        chk("t1_ifid_en", int'(ifid_en), 1);
        chk("t1_memwr_en", int'(memwr_en), 1);
        chk("t1_ifid_flush", int'(ifid_flush), 0);
        chk("t1_stall", int'(stall_cycles), 0);
        chk("t1_halt", int'(halt), 0);

        // load-use: lw x5 in ID/EX, add x6,x5,x7 in IF/ID
        cyc(); idle();
        idex_dmemREN = 1'b1; idex_RegWr = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd7;
        @(negedge CLK);
        chk("t2_pc_en", int'(pc_en), 0);
        chk("t2_ifid_en", int'(ifid_en), 0);
        chk("t2_idex_flush", int'(idex_flush), 1);
        cyc(); idle();
        exmem_rd = 5'd5; exmem_RegWr = 1'b1; exmem_dmemREN = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd7;
        @(negedge CLK);
        chk("t2_stall_after", int'(stall_cycles), 1);
`ifdef FORWARDING_EN
        chk("t2_pc_en_2nd", int'(pc_en), 1);
`else
        chk("t2_pc_en_2nd", int'(pc_en), 0);
`endif
        cyc(); idle();
        memwr_rd = 5'd5; memwr_RegWr = 1'b1; idex_rs1 = 5'd5; idex_rs2 = 5'd7;
        @(negedge CLK);
`ifdef FORWARDING_EN
        chk("t2_fwdA", int'(fwdA), 2);
        chk("t2_stall_total", int'(stall_cycles), 1);
`else
        chk("t2_fwdA", int'(fwdA), 0);
        chk("t2_stall_total", int'(stall_cycles), 2);
`endif

        // ALU producer in EX/MEM beats MEM/WR; x0 producers never match
        cyc(); idle();
        exmem_rd = 5'd5; exmem_RegWr = 1'b1; memwr_rd = 5'd5; memwr_RegWr = 1'b1;
        idex_rs1 = 5'd5; idex_rs2 = 5'd5;
        @(negedge CLK);
`ifdef FORWARDING_EN
        chk("t3_fwdA", int'(fwdA), 1);
        chk("t3_fwdB", int'(fwdB), 1);
`else
        chk("t3_fwdA", int'(fwdA), 0);
        chk("t3_fwdB", int'(fwdB), 0);
`endif
        chk("t3_pc_en", int'(pc_en), 1);
        cyc(); idle();
        exmem_rd = 5'd0; exmem_RegWr = 1'b1; memwr_rd = 5'd5; memwr_RegWr = 1'b1;
        idex_rs1 = 5'd5; idex_rs2 = 5'd0;
        idex_rd = 5'd0; idex_RegWr = 1'b1; idex_dmemREN = 1'b1;
        @(negedge CLK);
`ifdef FORWARDING_EN
        chk("t3_x0_fwdA", int'(fwdA), 2);
`else
        chk("t3_x0_fwdA", int'(fwdA), 0);
`endif
        chk("t3_x0_fwdB", int'(fwdB), 0);
        chk("t3_x0_pc_en", int'(pc_en), 1);

        // store miss with a taken branch pending: 4 frozen cycles, flush on the dhit cycle
        cyc(); idle();
        exmem_MemWr = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t4_freeze_pc_en", int'(pc_en), 0);
            chk("t4_freeze_exmem_en", int'(exmem_en), 0);
            chk("t4_freeze_ifid_flush", int'(ifid_flush), 0);
            cyc();
        end
        dhit = 1'b1;
        @(negedge CLK);
        chk("t4_release_pc_en", int'(pc_en), 1);
        chk("t4_release_ifid_flush", int'(ifid_flush), 1);
        chk("t4_release_idex_flush", int'(idex_flush), 1);

        // halt: detect cycle, DC drain cycles, then sticky halt until reset
        cyc(); idle();
        exmem_halt = 1'b1;
        @(negedge CLK);
        chk("t5_detect_pc_en", int'(pc_en), 0);
        chk("t5_detect_ifid_flush", int'(ifid_flush), 1);
        cyc(); exmem_halt = 1'b0;
        for (int i = 0; i < DC; i++) begin
            @(negedge CLK);
            chk("t5_drain_halt", int'(halt), 0);
            chk("t5_drain_exmem_en", int'(exmem_en), 1);
            cyc();
        end
        @(negedge CLK);
        chk("t5_halt", int'(halt), 1);
        chk("t5_halt_exmem_en", int'(exmem_en), 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge CLK);
            chk("t5_halt_sticky", int'(halt), 1);
        end
        cyc(); RST = 1'b1;
        @(negedge CLK);
        chk("t5_rst_idex_flush", int'(idex_flush), 1);
        cyc(); RST = 1'b0;
        @(negedge CLK);
        chk("t5_after_rst_halt", int'(halt), 0);
        chk("t5_after_rst_pc_en", int'(pc_en), 1);

        // long imem miss saturates the stall counter
        cyc(); idle(); ihit = 1'b0;
        repeat (300) cyc();
        @(negedge CLK);
        chk("t6_saturated", int'(stall_cycles), SMAX);
        cyc(); ihit = 1'b1;
        @(negedge CLK);
        chk("t6_no_wrap", int'(stall_cycles), SMAX);

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            cyc();
            RST           = ($urandom_range(0, 99) == 0);
            ihit          = ($urandom_range(0, 7) != 0);
            dhit          = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            exmem_halt    = ($urandom_range(0, 59) == 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            idex_rs1      = 5'($urandom_range(0, 3));
            idex_rs2      = 5'($urandom_range(0, 3));
            idex_rd       = 5'($urandom_range(0, 3));
            exmem_rd      = 5'($urandom_range(0, 3));
            memwr_rd      = 5'($urandom_range(0, 3));
            idex_RegWr    = ($urandom_range(0, 1) == 1);
            idex_dmemREN  = ($urandom_range(0, 2) == 0);
            exmem_RegWr   = ($urandom_range(0, 1) == 1);
            exmem_dmemREN = ($urandom_range(0, 2) == 0);
            exmem_MemWr   = ($urandom_range(0, 3) == 0);
            memwr_RegWr   = ($urandom_range(0, 1) == 1);
        end
        cyc();
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
